// File: rtl/driver_aligned.sv
// Stimulus driver that drives operands to the DUT, measures its pipeline latency in-band
// with an all-zero probe, and presents the operands re-aligned to the DUT result.
module driver_aligned #(
  parameter int WIDTH       = 32,
  parameter int NUM_OPS     = 2,
  parameter int MAX_DELAY   = 15,
  parameter int PERIOD_LOG2 = 16
) (
  input  logic                     clk_dut,
  input  logic                     reset_n,
  input  logic [NUM_OPS*WIDTH-1:0] i_rand,
  input  logic [WIDTH-1:0]         i_dut_out,
  input  logic                     i_remeasure,
  output logic [NUM_OPS*WIDTH-1:0] o_drive,
  output logic [NUM_OPS*WIDTH-1:0] o_drive_delayed,
  output logic                     o_delayed_valid,
  output logic [WIDTH-1:0]         o_dut_delay,
  output logic                     o_timeout
);

  localparam int CW = $clog2(MAX_DELAY + 1);
  localparam int BW = NUM_OPS * WIDTH;

  typedef enum logic [4:0] {
    FLUSH = 5'b00001,
    ARM   = 5'b00010,
    COUNT = 5'b00100,
    DONE  = 5'b01000,
    FAIL  = 5'b10000
  } state_e;

  state_e                 state_q, state_d;
  logic [PERIOD_LOG2-1:0] pcnt_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          dly_q, dly_d;
  logic [BW-1:0]          a0_q;
  logic [BW-1:0]          stage_q [1:MAX_DELAY];
  logic                   probe;
  logic [BW-1:0]          tapSel;

  assign probe = (state_q == ARM) && (&pcnt_q);

  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FLUSH;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_q + PERIOD_LOG2'(1);
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  // A zero result is only trusted as the probe echo once FLUSH has seen live data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    case (state_q)
      FLUSH: if (i_dut_out != '0) state_d = ARM;
      ARM: begin
        if (&pcnt_q) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (i_dut_out == '0) begin
          state_d = DONE;
          dly_d   = cnt_q;
        end else if (cnt_q == CW'(MAX_DELAY)) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    if (i_remeasure) state_d = FLUSH;
      FAIL:    if (i_remeasure) state_d = FLUSH;
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      a0_q <= '0;
      for (int k = 1; k <= MAX_DELAY; k++) stage_q[k] <= '0;
    end else begin
      a0_q       <= probe ? '0 : i_rand;
      stage_q[1] <= a0_q;
      for (int k = 2; k <= MAX_DELAY; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  always_comb begin
    tapSel = a0_q;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (dly_q == CW'(k)) tapSel = stage_q[k];
    end
  end

  assign o_drive         = a0_q;
  assign o_drive_delayed = tapSel;
  assign o_delayed_valid = (state_q == DONE);
  assign o_timeout       = (state_q == FAIL);
  assign o_dut_delay     = (state_q == DONE) ? WIDTH'(dly_q) : '1;

endmodule

// File: tb/tb_driver_aligned.sv
// Randomised bench for driver_aligned: a configurable-latency adder DUT model plus a
// timestamp-based reference predicting probe slot, verdict edge and aligned operands.
module tb_driver_aligned;

  localparam int WIDTH       = 32;
  localparam int NUM_OPS     = 2;
  localparam int MAX_DELAY   = 7;
  localparam int PERIOD_LOG2 = 4;
  localparam int PERIOD      = 1 << PERIOD_LOG2;
  localparam int BW          = NUM_OPS * WIDTH;
  localparam int HN          = 1024;
  localparam int PIPE        = 16;

  logic             clk = 1'b0;
  logic             rstN;
  logic [BW-1:0]    randIn;
  logic [WIDTH-1:0] dutOut;
  logic             remeasure;
  logic [BW-1:0]    oDrive, oDriveDelayed;
  logic             oValid, oTimeout;
  logic [WIDTH-1:0] oDutDelay;

  always #5 clk = ~clk;

  driver_aligned #(
    .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .MAX_DELAY(MAX_DELAY), .PERIOD_LOG2(PERIOD_LOG2)
  ) dut (
    .clk_dut(clk), .reset_n(rstN), .i_rand(randIn), .i_dut_out(dutOut),
    .i_remeasure(remeasure), .o_drive(oDrive), .o_drive_delayed(oDriveDelayed),
    .o_delayed_valid(oValid), .o_dut_delay(oDutDelay), .o_timeout(oTimeout)
  );

  // Arithmetic DUT: sum of all channels, `lat` register stages deep, or stuck at 1.
  int            lat;
  bit            stuck;
  logic [BW-1:0] pipe [0:PIPE-1];

  function automatic logic [WIDTH-1:0] sumOps(input logic [BW-1:0] v);
    logic [WIDTH-1:0] s = '0;
    for (int k = 0; k < NUM_OPS; k++) s = s + v[k*WIDTH +: WIDTH];
    return s;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= oDrive;
    for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    if (stuck)         dutOut = 32'h1;
    else if (lat == 0) dutOut = sumOps(oDrive);
    else               dutOut = sumOps(pipe[lat-1]);
  end

  int compareCount = 0;
  int mismatchCount = 0;

  int               n;
  bit               meas, live;
  int               probeEdge, verdictEdge, verdictKind, verdict, curD, pendD;
  logic [BW-1:0]    hist [0:HN-1];
  logic [WIDTH-1:0] preDut;
  logic [BW-1:0]    preRand;
  bit               preRem;

  task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Channels stay below 2^31 and odd, so operands and their sum are never zero.
  task automatic applyStimulus(input bit rem);
    for (int k = 0; k < NUM_OPS; k++) randIn[k*WIDTH +: WIDTH] = ($urandom >> 1) | 32'h1;
    remeasure = rem;
  endtask

  task automatic modelReset();
    meas = 1; live = 0; probeEdge = -1; verdict = 0; curD = 0; n = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Drive"},   oDrive, '0);
    checkOutput({tag, "Delayed"}, oDriveDelayed, '0);
    checkOutput({tag, "Valid"},   oValid, 0);
    checkOutput({tag, "Delay"},   oDutDelay, {WIDTH{1'b1}});
    checkOutput({tag, "Timeout"}, oTimeout, 0);
  endtask

  // One clock edge: capture what the DUT will sample, then predict and compare.
  task automatic step();
    bit               expProbe;
    logic [BW-1:0]    expDrive;
    logic [WIDTH-1:0] expDelay;
    @(negedge clk);
    preDut = dutOut; preRand = randIn; preRem = remeasure;
    @(posedge clk);
    #1;
    n++;
    expProbe = meas && live && probeEdge < 0 && (n % PERIOD == 0);
    if (!meas) begin
      if (preRem) begin
        meas = 1; live = 0; probeEdge = -1; verdict = 0;
      end
    end else if (expProbe) begin
      probeEdge = n;
      if (stuck || lat > MAX_DELAY) begin
        verdictEdge = n + MAX_DELAY + 1; verdictKind = 2;
      end else begin
        verdictEdge = n + lat + 1; verdictKind = 1; pendD = lat;
      end
    end else if (probeEdge >= 0 && n == verdictEdge) begin
      meas = 0; verdict = verdictKind;
      if (verdictKind == 1) curD = pendD;
    end else if (!live && probeEdge < 0 && preDut != '0) begin
      live = 1;
    end
    expDrive = expProbe ? '0 : preRand;
    hist[n % HN] = expDrive;
    expDelay = (verdict == 1) ? WIDTH'(curD) : {WIDTH{1'b1}};
    checkOutput("drive",    oDrive, expDrive);
    checkOutput("valid",    oValid, verdict == 1);
    checkOutput("timeout",  oTimeout, verdict == 2);
    checkOutput("dutDelay", oDutDelay, expDelay);
    checkOutput("delayed",  oDriveDelayed, hist[(n - curD) % HN]);
    if (verdict == 1 && !stuck && lat == curD)
      checkOutput("monitor", sumOps(oDriveDelayed), dutOut);
  endtask

  task automatic runPhase(input int count, input bit pulseInCount);
    for (int i = 0; i < count; i++) begin
      step();
      applyStimulus(pulseInCount && probeEdge == n);
    end
  endtask

  initial begin
    int waited;
    for (int i = 0; i < PIPE; i++) pipe[i] = '0;
    rstN = 1'b0; stuck = 0; lat = 0;
    applyStimulus(0);
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(posedge clk);
    #3 rstN = 1'b1;
    modelReset();

    // Combinational DUT gives D = 0.
    runPhase(40, 0);
    checkOutput("doneLat0", oValid, 1);
    checkOutput("delayLat0", oDutDelay, 0);

    lat = 3; applyStimulus(1);
    runPhase(40, 0);
    checkOutput("delayLat3", oDutDelay, 3);

    // Re-measure to 5 stages with a stray pulse during COUNT.
    lat = 5; applyStimulus(1);
    runPhase(40, 1);
    checkOutput("delayLat5", oDutDelay, 5);

    stuck = 1; applyStimulus(1);
    runPhase(40, 0);
    checkOutput("stuckTimeout", oTimeout, 1);
    checkOutput("stuckValid", oValid, 0);

    // One stage beyond the delay line must time out.
    stuck = 0; lat = MAX_DELAY + 1; applyStimulus(1);
    runPhase(40, 0);
    checkOutput("overTimeout", oTimeout, 1);

    // Asynchronous reset two cycles after the probe.
    lat = 2; applyStimulus(1);
    step(); applyStimulus(0);
    waited = 0;
    while (probeEdge < 0 && waited < 40) begin
      step(); applyStimulus(0); waited++;
    end
    checkOutput("probeSeen", probeEdge >= 0, 1);
    runPhase(2, 0);
    #2 rstN = 1'b0;
    #1 checkResetValues("midReset");
    modelReset();
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    runPhase(40, 0);
    checkOutput("delayLat2", oDutDelay, 2);

    lat = MAX_DELAY; applyStimulus(1);
    runPhase(300, 0);
    checkOutput("delayMax", oDutDelay, MAX_DELAY);
    checkOutput("validMax", oValid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
